// File: rtl/imem_pkg.sv
`default_nettype none
// ============================================================================
// Module  : imem_pkg
// Brief   : Shared types, constants and address check for the imem responder.
// Revision: 1.0 - initial release
// ============================================================================
package imem_pkg;

    typedef logic [31:0] word_t;

    localparam word_t NOP_INSTR    = 32'h00000000;
    localparam word_t RESET_VECTOR = 32'h80000000;

    // True when a byte address cannot name a word of the array.
    function automatic logic addr_bad(input word_t addr, input word_t base,
                                      input int unsigned depth);
        word_t off;
        off = addr - base;
        return (addr[1:0] != 2'b00) || (addr < base) || ((off >> 2) >= depth);
    endfunction

endpackage
`default_nettype wire

// File: rtl/imem_fetch_resp_if.sv
`default_nettype none
// ============================================================================
// Module  : imem_fetch_resp_if
// Brief   : Fetch request/response and program-load bus of the imem responder.
// Revision: 1.0 - initial release
// ============================================================================
interface imem_fetch_resp_if;
    import imem_pkg::*;

    logic  req_valid;
    logic  req_ready;
    word_t req_addr;
    logic  rsp_valid;
    logic  rsp_ready;
    word_t rsp_instr;
    logic  rsp_fault;
    logic  wr_en;
    word_t wr_addr;
    word_t wr_data;

    modport master (
        output req_valid, req_addr, rsp_ready, wr_en, wr_addr, wr_data,
        input  req_ready, rsp_valid, rsp_instr, rsp_fault
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready, wr_en, wr_addr, wr_data,
        output req_ready, rsp_valid, rsp_instr, rsp_fault
    );

endinterface
`default_nettype wire

// File: rtl/imem_resp_fifo.sv
`default_nettype none
// ============================================================================
// Module  : imem_resp_fifo
// Brief   : Synchronous FIFO, extra-bit pointers, active-low async reset.
// Revision: 1.0 - initial release
// ============================================================================
module imem_resp_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             i_push,
    input  wire logic [WIDTH-1:0] i_din,
    input  wire logic             i_pop,
    output logic      [WIDTH-1:0] o_dout,
    output logic                  o_full,
    output logic                  o_empty
);

    localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [2**c_AW];
    logic [c_AW:0]    r_wptr;
    logic [c_AW:0]    r_rptr;
    logic [c_AW:0]    w_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_count   = r_wptr - r_rptr;
    assign o_empty   = (w_count == '0);
    assign o_full    = (w_count == (c_AW+1)'(DEPTH));
    assign w_do_pop  = i_pop && !o_empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_dout    = r_mem[r_rptr[c_AW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr[c_AW-1:0]] <= i_din;
    end

endmodule
`default_nettype wire

// File: rtl/imem_fetch_resp.sv
`default_nettype none
// ============================================================================
// Module  : imem_fetch_resp
// Brief   : Instruction memory with fixed-latency, credit-controlled fetch.
//           Build macro IMEM_TRACE_EN prints each response as it is queued.
// Revision: 1.0 - initial release
// ============================================================================
module imem_fetch_resp
    import imem_pkg::*;
#(
    parameter int    DEPTH_WORDS = 256,
    parameter word_t BASE_ADDR   = RESET_VECTOR,
    parameter int    LATENCY     = 2,
    parameter int    FIFO_DEPTH  = 4
) (
    input wire logic          clk,
    input wire logic          reset,
    imem_fetch_resp_if.slave  bus
);

    localparam int c_IDX_W  = $clog2(DEPTH_WORDS);
    localparam int c_CRED_W = $clog2(FIFO_DEPTH + 1);

    word_t                r_mem [DEPTH_WORDS];
    logic                 r_stg_valid [LATENCY];
    word_t                r_stg_instr [LATENCY];
    logic                 r_stg_fault [LATENCY];
    logic [c_CRED_W-1:0]  r_credits;

    logic [c_IDX_W-1:0]   w_rd_idx;
    logic [c_IDX_W-1:0]   w_wr_idx;
    logic                 w_rd_fault;
    logic                 w_accept;
    logic                 w_pop;
    logic                 w_req_ready;
    logic [32:0]          w_fifo_dout;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;

    assign w_rd_idx    = c_IDX_W'((bus.req_addr - BASE_ADDR) >> 2);
    assign w_wr_idx    = c_IDX_W'((bus.wr_addr - BASE_ADDR) >> 2);
    assign w_rd_fault  = addr_bad(bus.req_addr, BASE_ADDR, DEPTH_WORDS);
    assign w_req_ready = reset && (r_credits != '0) && !w_fifo_full;
    assign w_accept    = bus.req_valid && w_req_ready;
    assign w_pop       = bus.rsp_ready && !w_fifo_empty;

    assign bus.req_ready = w_req_ready;
    assign bus.rsp_valid = !w_fifo_empty;
    assign bus.rsp_instr = w_fifo_empty ? NOP_INSTR : w_fifo_dout[31:0];
    assign bus.rsp_fault = !w_fifo_empty && w_fifo_dout[32];

    // Program image: no reset, so a preload may run while reset is held.
    always_ff @(posedge clk) begin
        if (bus.wr_en && !addr_bad(bus.wr_addr, BASE_ADDR, DEPTH_WORDS))
            r_mem[w_wr_idx] <= bus.wr_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < LATENCY; s++) begin
                r_stg_valid[s] <= 1'b0;
                r_stg_instr[s] <= NOP_INSTR;
                r_stg_fault[s] <= 1'b0;
            end
        end else begin
            r_stg_valid[0] <= w_accept;
            r_stg_instr[0] <= w_rd_fault ? NOP_INSTR : r_mem[w_rd_idx];
            r_stg_fault[0] <= w_rd_fault;
            for (int s = 1; s < LATENCY; s++) begin
                r_stg_valid[s] <= r_stg_valid[s-1];
                r_stg_instr[s] <= r_stg_instr[s-1];
                r_stg_fault[s] <= r_stg_fault[s-1];
            end
        end
    end

    // Credits cover pipeline plus FIFO, so a push always finds a free slot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_credits <= c_CRED_W'(FIFO_DEPTH);
        end else begin
            case ({w_accept, w_pop})
                2'b10:   r_credits <= r_credits - 1'b1;
                2'b01:   r_credits <= r_credits + 1'b1;
                default: r_credits <= r_credits;
            endcase
        end
    end

    imem_resp_fifo #(
        .WIDTH (33),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (r_stg_valid[LATENCY-1]),
        .i_din   ({r_stg_fault[LATENCY-1], r_stg_instr[LATENCY-1]}),
        .i_pop   (w_pop),
        .o_dout  (w_fifo_dout),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

`ifdef IMEM_TRACE_EN
    word_t r_stg_addr [LATENCY];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < LATENCY; s++) r_stg_addr[s] <= '0;
        end else begin
            r_stg_addr[0] <= bus.req_addr;
            for (int s = 1; s < LATENCY; s++) r_stg_addr[s] <= r_stg_addr[s-1];
        end
    end

    always @(posedge clk) begin
        if (reset && r_stg_valid[LATENCY-1])
            $display("IMEM: %h -> %h%s", r_stg_addr[LATENCY-1],
                     r_stg_instr[LATENCY-1],
                     r_stg_fault[LATENCY-1] ? " FAULT" : "");
    end
`else
    // Trace disabled: no address history is kept.
`endif

endmodule
`default_nettype wire
